tdm_demux_rx: RTL and testbench
===============================

TDM_DEMUX_RX -- requirements
Module: tdm_demux_rx

Interface
REQ-001 Parameter WIDTH, default 4: bit width of each data beat and of each channel output.
REQ-002 Parameter SLOTS, fixed 4: slots per frame; the block SHALL support only the value 4.
REQ-003 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 enable  in  1  high = accept beats; low = ignore inputs and hold all state.
REQ-006 in_data  in  WIDTH  time-multiplexed data beat.
REQ-007 in_valid  in  1  in_data is a beat this cycle.
REQ-008 in_sof  in  1  start of frame; qualified by in_valid; marks slot 0.
REQ-009 ch0, ch1, ch2, ch3  out  WIDTH each  last complete frame, slot 0..3 respectively.
REQ-010 frame_done  out  1  one-cycle pulse after a complete frame is committed.
REQ-011 sync_err  out  1  one-cycle pulse when a framing violation is detected.
REQ-012 locked  out  1  high while the FSM is in RECV.
REQ-013 err_count  out  8  saturating count of sync_err pulses.

Function
REQ-014 The FSM SHALL have two states: HUNT (unsynchronised) and RECV (synchronised); `locked` = (state==RECV).
REQ-015 A beat is accepted when enable & in_valid at a rising clk edge; no other cycle SHALL alter state.
REQ-016 In HUNT, a beat with in_sof SHALL write shadow slot 0, set the slot pointer to 1, and go to RECV.
REQ-017 In HUNT, a beat without in_sof SHALL be discarded without an error.
REQ-018 In RECV with slot pointer 1..3 and in_sof low, the beat SHALL be written to the shadow at the slot pointer, and the pointer SHALL increment.
REQ-019 Slot-3 commit:
- On accepting the slot-3 beat, ch0..ch3 SHALL all update at that same edge, from shadow 0..2 plus the current beat.
- frame_done SHALL be high for exactly the following cycle.
- The pointer SHALL wrap to 0, and the FSM SHALL remain in RECV.
REQ-020 In RECV with pointer 0, a beat with in_sof SHALL be treated as slot 0 (write shadow 0, pointer to 1).
REQ-021 In RECV with pointer 0, a beat without in_sof SHALL:
- pulse sync_err,
- discard the beat,
- return to HUNT.
REQ-022 In RECV with pointer 1..3, a beat with in_sof SHALL:
- pulse sync_err,
- abandon the partial frame (ch outputs unchanged),
- store the beat as slot 0, set the pointer to 1, and remain in RECV.
REQ-023 ch0..ch3 SHALL change only on a slot-3 commit; a partial frame SHALL never be visible.
REQ-024 frame_done and sync_err SHALL never be high in the same cycle.
REQ-025 err_count SHALL increment on each sync_err pulse and saturate at 255.
REQ-026 With enable low, an in-progress frame SHALL be preserved and SHALL resume when enable returns high.
REQ-027 Latency: a frame's last beat accepted at edge N SHALL appear on ch0..ch3 and frame_done after edge N.

Reset
REQ-028 When reset is high, the block SHALL immediately force:
- state to HUNT, pointer to 0, shadow to 0,
- ch0..ch3 to 0,
- frame_done, sync_err and err_count to 0.
REQ-029 On reset asserted mid-frame, the partial frame SHALL be lost, and no frame_done SHALL follow release.
REQ-030 The first beat after reset release SHALL be handled as in HUNT.

Structure
REQ-031 A shared package SHALL hold:
- the HUNT/RECV state encoding,
- the SLOTS constant (4),
- the slot-pointer width (2),
- the err_count width (8).
REQ-032 The block SHALL be a single module; no sub-module is required.

Verification
REQ-033 Reset, then beats 0x1(sof), 0x2, 0x3, 0x4 on consecutive cycles -> ch0..ch3 = 1, 2, 3, 4 after the 4th edge; one frame_done pulse; locked high from the 2nd cycle.
REQ-034 Beats 0xA(sof), 0xB, then 0xC(sof), 0xD, 0xE, 0xF -> sync_err pulse on the 3rd beat; err_count = 1; ch0..ch3 = C, D, E, F; outputs unchanged before that.
REQ-035 Frame 5, 6, 7, 8, then a non-sof beat 0x9 -> sync_err; locked drops; further non-sof beats are ignored until the next sof.
REQ-036 Frame with enable low for 3 cycles between beats 2 and 3, in_valid toggling during the gap -> the frame completes correctly with no error.
REQ-037 Reset pulse after 2 beats of a frame -> all outputs 0; the remaining 2 beats produce no frame_done; state HUNT.
REQ-038 300 consecutive sync_err events -> err_count holds at 255.

Source files
------------

// File: rtl/tdm_demux_rx_pkg.sv
// rtl/tdm_demux_rx_pkg.sv - shared constants, state encoding and helpers for the TDM receiver
package tdm_demux_rx_pkg;

    localparam int SLOTS_PER_FRAME = 4;
    localparam int PTR_W           = 2;
    localparam int ERR_W           = 8;

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    // Saturating increment: an all-ones count stays put.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/tdm_demux_rx_if.sv
// rtl/tdm_demux_rx_if.sv - time-multiplexed input beat bundle
interface tdm_demux_rx_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_sof;

    modport master (output enable, in_data, in_valid, in_sof);
    modport slave  (input  enable, in_data, in_valid, in_sof);
endinterface

// File: rtl/tdm_demux_rx.sv
// rtl/tdm_demux_rx.sv - 4-slot TDM frame demultiplexer with framing check
module tdm_demux_rx
    import tdm_demux_rx_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SLOTS = SLOTS_PER_FRAME
) (
    input  logic               clk,
    input  logic               reset,
    tdm_demux_rx_if.slave      bus,
    output logic [WIDTH-1:0]   ch0,
    output logic [WIDTH-1:0]   ch1,
    output logic [WIDTH-1:0]   ch2,
    output logic [WIDTH-1:0]   ch3,
    output logic               frame_done,
    output logic               sync_err,
    output logic               locked,
    output logic [ERR_W-1:0]   err_count
);

    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(SLOTS - 1);

    state_t                          state_q, state_d;
    logic [PTR_W-1:0]                ptr_q, ptr_d;
    // Slots 0..2 are held here; slot 3 goes straight to the outputs on commit.
    logic [SLOTS-2:0][WIDTH-1:0]     shadow_q, shadow_d;
    logic [SLOTS-1:0][WIDTH-1:0]     ch_q, ch_d;
    logic                            frame_done_q, frame_done_d;
    logic                            sync_err_q, sync_err_d;
    logic [ERR_W-1:0]                err_count_q, err_count_d;
    logic                            accept;

    // Next-state: framing FSM, shadow fill, commit and error accounting.
    always_comb begin
        accept       = bus.enable & bus.in_valid;
        state_d      = state_q;
        ptr_d        = ptr_q;
        shadow_d     = shadow_q;
        ch_d         = ch_q;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        if (accept) begin
            case (state_q)
                HUNT: begin
                    // Non-sof beats while unsynchronised are dropped silently.
                    if (bus.in_sof) begin
                        shadow_d[0] = bus.in_data;
                        ptr_d       = PTR_W'(1);
                        state_d     = RECV;
                    end
                end
                RECV: begin
                    if (ptr_q == '0) begin
                        if (bus.in_sof) begin
                            shadow_d[0] = bus.in_data;
                            ptr_d       = PTR_W'(1);
                        end else begin
                            sync_err_d = 1'b1;
                            state_d    = HUNT;
                        end
                    end else if (bus.in_sof) begin
                        // Early sof: drop the partial frame and restart from this beat.
                        sync_err_d  = 1'b1;
                        shadow_d[0] = bus.in_data;
                        ptr_d       = PTR_W'(1);
                    end else if (ptr_q == LAST_SLOT) begin
                        ch_d         = {bus.in_data, shadow_q[2], shadow_q[1], shadow_q[0]};
                        frame_done_d = 1'b1;
                        ptr_d        = '0;
                    end else begin
                        shadow_d[ptr_q] = bus.in_data;
                        ptr_d           = ptr_q + PTR_W'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        err_count_d = sync_err_d ? sat_inc(err_count_q) : err_count_q;
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= HUNT;
            ptr_q        <= '0;
            shadow_q     <= '0;
            ch_q         <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            shadow_q     <= shadow_d;
            ch_q         <= ch_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign ch0        = ch_q[0];
    assign ch1        = ch_q[1];
    assign ch2        = ch_q[2];
    assign ch3        = ch_q[3];
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
    assign locked     = (state_q == RECV);
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_tdm_demux_rx.sv
// tb/tb_tdm_demux_rx.sv - directed self-checking bench for tdm_demux_rx
module tb_tdm_demux_rx;

    logic       clk;
    logic       reset;
    logic [3:0] ch0, ch1, ch2, ch3;
    logic       frame_done, sync_err, locked;
    logic [7:0] err_count;
    int         n_checks;
    int         n_pass;

    tdm_demux_rx_if #(.WIDTH(4)) bus ();

    tdm_demux_rx #(.WIDTH(4), .SLOTS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .ch0        (ch0),
        .ch1        (ch1),
        .ch2        (ch2),
        .ch3        (ch3),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .locked     (locked),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge; return 1 time unit after the next rising edge.
    task automatic cyc(input logic en, input logic v, input logic sof, input logic [3:0] d);
        @(negedge clk);
        bus.enable   = en;
        bus.in_valid = v;
        bus.in_sof   = sof;
        bus.in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) $display("FAIL %s got %h want %h", name, got, want);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ch", {16'h0, ch0, ch1, ch2, ch3}, 32'h0);
        chk("reset_flags", {29'h0, frame_done, sync_err, locked}, 32'h0);
        chk("reset_errcnt", {24'h0, err_count}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic_frame();
        cyc(1, 1, 1, 4'h1);
        chk("basic_locked_b1", {31'h0, locked}, 32'h1);
        chk("basic_nopartial_b1", {16'h0, ch0, ch1, ch2, ch3}, 32'h0);
        cyc(1, 1, 0, 4'h2);
        cyc(1, 1, 0, 4'h3);
        chk("basic_nopartial_b3", {16'h0, ch0, ch1, ch2, ch3}, 32'h0);
        chk("basic_nodone_b3", {31'h0, frame_done}, 32'h0);
        cyc(1, 1, 0, 4'h4);
        chk("basic_ch", {16'h0, ch0, ch1, ch2, ch3}, 32'h1234);
        chk("basic_done", {30'h0, frame_done, sync_err}, 32'h2);
        cyc(0, 0, 0, 4'h0);
        chk("basic_done_1cyc", {31'h0, frame_done}, 32'h0);
        chk("basic_hold", {16'h0, ch0, ch1, ch2, ch3}, 32'h1234);
    endtask

    task automatic test_resync();
        cyc(1, 1, 1, 4'hA);
        cyc(1, 1, 0, 4'hB);
        cyc(1, 1, 1, 4'hC);
        chk("resync_err", {30'h0, sync_err, frame_done}, 32'h2);
        chk("resync_errcnt", {24'h0, err_count}, 32'h1);
        chk("resync_ch_held", {16'h0, ch0, ch1, ch2, ch3}, 32'h1234);
        chk("resync_locked", {31'h0, locked}, 32'h1);
        cyc(1, 1, 0, 4'hD);
        chk("resync_err_1cyc", {31'h0, sync_err}, 32'h0);
        cyc(1, 1, 0, 4'hE);
        cyc(1, 1, 0, 4'hF);
        chk("resync_ch", {16'h0, ch0, ch1, ch2, ch3}, 32'hCDEF);
        chk("resync_done", {30'h0, frame_done, sync_err}, 32'h2);
    endtask

    task automatic test_back_to_back_and_loss();
        cyc(1, 1, 1, 4'h5);
        chk("b2b_done_clear", {31'h0, frame_done}, 32'h0);
        cyc(1, 1, 0, 4'h6);
        cyc(1, 1, 0, 4'h7);
        cyc(1, 1, 0, 4'h8);
        chk("b2b_ch", {16'h0, ch0, ch1, ch2, ch3}, 32'h5678);
        cyc(1, 1, 0, 4'h9);
        chk("loss_err", {30'h0, sync_err, locked}, 32'h2);
        chk("loss_errcnt", {24'h0, err_count}, 32'h2);
        cyc(1, 1, 0, 4'h1);
        cyc(1, 1, 0, 4'h2);
        chk("loss_ignored", {29'h0, sync_err, locked, frame_done}, 32'h0);
        chk("loss_errcnt_held", {24'h0, err_count}, 32'h2);
        chk("loss_ch_held", {16'h0, ch0, ch1, ch2, ch3}, 32'h5678);
        cyc(1, 1, 1, 4'h3);
        chk("loss_relock", {31'h0, locked}, 32'h1);
        cyc(1, 1, 0, 4'h4);
        cyc(1, 1, 0, 4'h5);
        cyc(1, 1, 0, 4'h6);
        chk("loss_ch_new", {16'h0, ch0, ch1, ch2, ch3}, 32'h3456);
    endtask

    task automatic test_enable_gap();
        cyc(1, 1, 1, 4'h7);
        cyc(1, 1, 0, 4'h8);
        cyc(0, 1, 1, 4'h1);
        cyc(0, 0, 0, 4'h2);
        cyc(0, 1, 0, 4'h3);
        chk("gap_noerr", {29'h0, sync_err, frame_done, locked}, 32'h1);
        cyc(1, 1, 0, 4'h9);
        cyc(1, 1, 0, 4'hA);
        chk("gap_ch", {16'h0, ch0, ch1, ch2, ch3}, 32'h789A);
        chk("gap_done", {30'h0, frame_done, sync_err}, 32'h2);
        chk("gap_errcnt", {24'h0, err_count}, 32'h2);
    endtask

    task automatic test_reset_midframe();
        cyc(1, 1, 1, 4'h1);
        cyc(1, 1, 0, 4'h2);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_ch", {16'h0, ch0, ch1, ch2, ch3}, 32'h0);
        chk("mid_rst_flags", {21'h0, err_count, frame_done, sync_err, locked}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cyc(1, 1, 0, 4'h3);
        cyc(1, 1, 0, 4'h4);
        chk("mid_rst_nodone", {29'h0, frame_done, sync_err, locked}, 32'h0);
        cyc(0, 0, 0, 4'h0);
        chk("mid_rst_ch_after", {16'h0, ch0, ch1, ch2, ch3}, 32'h0);
    endtask

    task automatic test_saturate();
        cyc(1, 1, 1, 4'h0);
        for (int i = 1; i <= 300; i++) begin
            cyc(1, 1, 1, 4'(i));
            if (i == 254) chk("sat_254", {24'h0, err_count}, 32'd254);
            if (i == 255) chk("sat_255", {24'h0, err_count}, 32'd255);
        end
        chk("sat_300", {24'h0, err_count}, 32'd255);
        chk("sat_pulse", {30'h0, sync_err, locked}, 32'h3);
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        reset        = 1'b1;
        bus.enable   = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = 4'h0;
        test_reset();
        test_basic_frame();
        test_resync();
        test_back_to_back_and_loss();
        test_enable_gap();
        test_reset_midframe();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
